// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of a fifo among
//   NREQ valid/ready producers. A winner may hold the port for up to BURST
//   consecutive words so short packets land contiguously in the fifo.
//
// Ports
//   clk           single clock, rising edge
//   rstn          asynchronous active-low reset
//   req_valid     per-requester valid
//   req_data      requester i word at [i*WIDTH +: WIDTH]
//   req_ready     one-hot (or zero) take strobe back to the requesters
//   full          fifo full flag
//   write_enable  fifo write strobe
//   write_data    selected word, unmodified
//   grant_id      index of the selected requester (meaningful with write_enable)
//   accept_count  free-running count of accepted words, wraps at 16 bits
module fifo_write_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int BURST = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      full,
    output logic                      write_enable,
    output logic [WIDTH-1:0]          write_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [15:0]               accept_count
);

    localparam int IW  = $clog2(NREQ);
    localparam int BW  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int BW1 = BW + 1;

    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  sel;
    logic           have_sel;
    logic           locked;
    logic [BW-1:0]  burst_cnt;
    logic [BW-1:0]  burst_nxt;
    logic [BW:0]    tenure_n;

    // An open tenure only holds the port while its owner keeps asking.
    always_comb locked = (burst_cnt != '0) && req_valid[last_grant];

    // Rotating priority: start just after the last winner, wrap, end on it.
    always_comb begin
        int idx;
        idx      = 0;
        have_sel = locked;
        sel      = locked ? last_grant : '0;
        if (!locked) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(last_grant) + k) % NREQ;
                if (!have_sel && req_valid[idx[IW-1:0]]) begin
                    have_sel = 1'b1;
                    sel      = idx[IW-1:0];
                end
            end
        end
    end

    // Outputs are forced quiet while reset is asserted, independent of the
    // clock, so nothing reaches the fifo during an asynchronous reset.
    always_comb begin
        req_ready    = '0;
        write_enable = 1'b0;
        write_data   = '0;
        grant_id     = '0;
        if (rstn && have_sel) begin
            req_ready[sel] = !full;
            write_enable   = !full;
            write_data     = req_data[sel*WIDTH +: WIDTH];
            grant_id       = sel;
        end
    end

    // Words taken in this tenure including the current one; reaching BURST
    // closes the tenure so the next cycle arbitrates fresh.
    always_comb begin
        tenure_n  = locked ? ({1'b0, burst_cnt} + BW1'(1)) : BW1'(1);
        burst_nxt = (tenure_n == BW1'(BURST)) ? '0 : tenure_n[BW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant   <= IW'(NREQ - 1);
            burst_cnt    <= '0;
            accept_count <= '0;
        end else if (write_enable) begin
            last_grant   <= sel;
            burst_cnt    <= burst_nxt;
            accept_count <= accept_count + 16'd1;
        end else if ((burst_cnt != '0) && !req_valid[last_grant]) begin
            burst_cnt <= '0;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter sharing the single write port of the team's `fifo` (WIDTH/DEPTH-parameterised, `write_enable`/`write_data`/`full`) among NREQ producers. Each producer uses a valid/ready handshake. The arbiter steers at most one producer's word into the FIFO per cycle and never writes while `full` is high. A configurable burst lock lets a winner keep the port for up to BURST consecutive words, which keeps short packets contiguous in the FIFO.

## Interface
- WIDTH, 4: data width; must match the downstream `fifo` WIDTH.
- NREQ, 4: number of requesters, 2..8.
- BURST, 2: maximum consecutive accepts per grant tenure, ≥1. BURST=1 gives pure round-robin.
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  bit i: requester i has a word.
- req_data  in  NREQ*WIDTH  requester i's word is at [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot or zero; bit i high means requester i's word is taken this cycle if valid.
- full  in  1  driven from the `fifo` full output.
- write_enable  out  1  to `fifo` write_enable.
- write_data  out  WIDTH  to `fifo` write_data; the selected word, passed bit-for-bit.
- grant_id  out  clog2(NREQ)  index of the currently selected requester; valid only when write_enable=1.
- accept_count  out  16  total accepted words since reset; wraps 0xFFFF→0.

## Operation
- Registered state:
  - last_grant (clog2(NREQ) bits): reset value NREQ-1, so requester 0 has first priority.
  - burst_cnt (0..BURST-1): reset value 0; 0 means no tenure is open.
  - accept_count: reset value 0.
- Selection (combinational):
  - Lock: if burst_cnt≠0 and req_valid[last_grant]=1, sel = last_grant.
  - Otherwise, sel = the first i with req_valid[i]=1, scanning last_grant+1, last_grant+2, … modulo NREQ, ending at last_grant itself.
  - If no request is valid, there is no selection.
- Handshake outputs:
  - req_ready[sel] = !full; all other bits are 0.
  - write_enable = req_valid[sel] && !full.
  - write_data = req_data of sel.
  - grant_id = sel.
  - With no valid request: write_enable=0, req_ready=0, write_data=0, grant_id=0.
- On accept (write_enable=1):
  - last_grant ← sel.
  - Let n = burst_cnt+1 if locked, else 1. Then burst_cnt ← (n==BURST) ? 0 : n.
  - accept_count ← accept_count+1.
- Owner drops valid while locked (burst_cnt≠0, req_valid[last_grant]=0):
  - Tenure ends: burst_cnt ← 0.
  - Arbitration proceeds round-robin in the same cycle. If another requester is accepted, the accept rule applies with n=1.
- full=1: no accept, and last_grant is held. burst_cnt is held only while the owner stays valid; the owner-drops-valid rule above still applies.
- No other state. The data path has no storage, so there is no added latency.

## Timing
- Word acceptance and the FIFO write happen in the same cycle. The FIFO samples write_enable/write_data at the same clk edge that updates the arbiter state.
- Latency from req_valid rising to acceptance:
  - 0 cycles when the requester wins and full=0.
  - Otherwise, worst case (NREQ-1)*BURST accepting cycles.
- `full` feeds write_enable combinationally. Overflow is impossible because the FIFO's full already reflects the current occupancy.
- req_data of the selected requester must be stable while its req_valid=1 and req_ready=0.
- Asynchronous reset mid-tenure:
  - All registers go to their reset values immediately.
  - Outputs follow combinationally: with rstn=0, write_enable=0 and req_ready=0 regardless of inputs.
- First edge after rstn deasserts: arbitration starts from requester 0.

## Test plan
- All four requester valids held high; BURST=2; full tied 0; each requester's data = 4'h1+i. Required:
  - grant_id sequence 0,0,1,1,2,2,3,3,0…
  - write_enable=1 every cycle.
  - accept_count=8 after 8 cycles.
- Only requester 2 valid for 5 cycles. Required:
  - Accepted every cycle; grant_id=2 throughout.
  - burst_cnt pattern 1,0,1,0,1.
  - req_ready=4'b0100.
- Arbiter wired to `fifo` WIDTH=4 DEPTH=4 with no reads; requester 0 sends 1,2,3,4,5. Required:
  - The first four words are written.
  - full=1 after the fourth write.
  - The fifth word is held (req_ready=0, write_enable=0) until one read occurs, then written.
  - Reads return 1,2,3,4,5 in order.
- Requesters 1 and 3 valid; BURST=4; requester 1 drops valid after 2 accepts. Required:
  - The next accept is grant_id=3 in the same cycle as the drop.
  - That accept leaves burst_cnt=1.
- Assert rstn=0 mid-tenure while requester 3 is locked (burst_cnt=1). Required:
  - write_enable=0 and req_ready=0 during reset.
  - After release, with requesters 0 and 3 valid, the first grant_id=0.
  - accept_count=0 immediately after reset.
- full=1 for 3 cycles while requesters 0 and 1 are valid. Required:
  - No write_enable; last_grant and accept_count are unchanged.
  - Arbitration resumes from the held last_grant once full=0.
